// File: rtl/uberlut_pkg.sv
// Shared definitions for the UberLUT serial configuration loader.
package uberlut_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUT_RST,
    ST_FETCH,
    ST_SHIFT,
    ST_WAIT_RDY,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic int total_bits(input int num_vars, input int num_varsel);
    return num_varsel * (1 << num_vars);
  endfunction

  // Width able to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uberlut_piso.sv
// Parallel-in serial-out shift register with a remaining-bit counter; load wins over shift.
module uberlut_piso #(
  parameter int WORD_W = 32,
  parameter int BITS_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic [BITS_W-1:0] load_bits_i,
  input  logic              shift_i,
  output logic              bit0_o,
  output logic              last_o
);

  logic [WORD_W-1:0] sr_q;
  logic [BITS_W-1:0] rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_data_i;
      rem_q <= load_bits_i;
    end else if (shift_i) begin
      sr_q  <= sr_q >> 1;
      rem_q <= rem_q - BITS_W'(1);
    end
  end

  assign bit0_o = sr_q[0];
  assign last_o = (rem_q == BITS_W'(1));

endmodule

// File: rtl/uberlut_loader.sv
// Streams packed configuration words LSB-first into an UberLUT, then waits for its ready flag.
module uberlut_loader
  import uberlut_pkg::*;
#(
  parameter int NUM_VARS   = 6,
  parameter int NUM_VARSEL = 2,
  parameter int WORD_W     = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              lut_rst,
  output logic              uberLUT_data,
  output logic              uberLUT_load,
  input  logic              lut_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOTAL_BITS = total_bits(NUM_VARS, NUM_VARSEL);
  localparam int CNT_W      = cnt_width(TOTAL_BITS);
  localparam int WB_W       = cnt_width(WORD_W);
  localparam int WT_W       = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              lut_rst_q, lut_rst_d;
  logic              load_q, load_d;
  logic              data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              piso_load, piso_shift, piso_bit, piso_last;
  logic [WB_W-1:0]   piso_bits;
  int                rem_bits;

  uberlut_piso #(
    .WORD_W(WORD_W),
    .BITS_W(WB_W)
  ) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (piso_load),
    .load_data_i(s_data),
    .load_bits_i(piso_bits),
    .shift_i    (piso_shift),
    .bit0_o     (piso_bit),
    .last_o     (piso_last)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = done_q;
    error_d    = error_q;
    load_d     = 1'b0;
    data_d     = 1'b0;
    s_ready    = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LUT_RST;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_LUT_RST: begin
        bit_cnt_d = '0;
        state_d   = ST_FETCH;
      end
      ST_FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          piso_load = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        piso_shift = 1'b1;
        load_d     = 1'b1;
        data_d     = piso_bit;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(TOTAL_BITS - 1)) begin
          state_d    = ST_WAIT_RDY;
          wait_cnt_d = '0;
        end else if (piso_last) begin
          // Request the next word in the same cycle as the last bit so streaming has no bubble.
          s_ready = 1'b1;
          if (s_valid) piso_load = 1'b1;
          else         state_d   = ST_FETCH;
        end
      end
      ST_WAIT_RDY: begin
        if (lut_ready) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WT_W'(1);
          if (wait_cnt_q == WT_W'(TIMEOUT - 1)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The final word is trimmed so no strobe is issued past the end of the LUT.
    rem_bits  = TOTAL_BITS - int'(bit_cnt_d);
    piso_bits = (rem_bits > WORD_W) ? WB_W'(WORD_W) : WB_W'(rem_bits);

    lut_rst_d = (state_d == ST_LUT_RST);
    busy_d    = state_d inside {ST_LUT_RST, ST_FETCH, ST_SHIFT, ST_WAIT_RDY};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lut_rst_q  <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lut_rst_q  <= lut_rst_d;
      load_q     <= load_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign lut_rst      = lut_rst_q;
  assign uberLUT_load = load_q;
  assign uberLUT_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_uberlut_loader.sv
// Bench for uberlut_loader: two instances (32- and 24-bit words) driven against a behavioural LUT model.
module tb_uberlut_loader;

  localparam int TOT = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, start_v, valid_v, lut_ready_v;
  logic [31:0] data_v;

  logic r32, lr32, ld32, d32, b32, dn32, e32;
  logic r24, lr24, ld24, d24, b24, dn24, e24;
  logic ready_m, lutrst_m, load_m, data_m, busy_m, done_m, error_m;

  assign ready_m  = sel ? r24  : r32;
  assign lutrst_m = sel ? lr24 : lr32;
  assign load_m   = sel ? ld24 : ld32;
  assign data_m   = sel ? d24  : d32;
  assign busy_m   = sel ? b24  : b32;
  assign done_m   = sel ? dn24 : dn32;
  assign error_m  = sel ? e24  : e32;

  uberlut_loader #(.NUM_VARS(6), .NUM_VARSEL(2), .WORD_W(32), .TIMEOUT(16)) u_dut32 (
    .clk(clk), .rst(rst_n), .start(start_v & ~sel), .s_data(data_v),
    .s_valid(valid_v & ~sel), .s_ready(r32), .lut_rst(lr32), .uberLUT_data(d32),
    .uberLUT_load(ld32), .lut_ready(lut_ready_v & ~sel), .busy(b32), .done(dn32), .error(e32));

  uberlut_loader #(.NUM_VARS(6), .NUM_VARSEL(2), .WORD_W(24), .TIMEOUT(16)) u_dut24 (
    .clk(clk), .rst(rst_n), .start(start_v & sel), .s_data(data_v[23:0]),
    .s_valid(valid_v & sel), .s_ready(r24), .lut_rst(lr24), .uberLUT_data(d24),
    .uberLUT_load(ld24), .lut_ready(lut_ready_v & sel), .busy(b24), .done(dn24), .error(e24));

  int          n_assert, n_fail;
  logic [31:0] words [8];
  bit          mem [TOT];
  bit          ready_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_words(input bit fixed, input bit ones_tail);
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    if (fixed) begin
      words[0] = 32'hA5A5_A5A5;
      words[1] = 32'h5A5A_5A5A;
    end
    if (ones_tail) words[5][23:8] = 16'hFFFF;
  endtask

  // One full load: start pulse, per-cycle LUT model and word source, then end-of-load checks.
  task automatic run_load(input bit gaps, input bit pokes, input int abort_at, input int ww);
    int  addr = 0, strobes = 0, rstcyc = 0, xfers = 0, widx = 0, gapcnt = 0;
    int  first_s = -1, last_s = -1, fin = -1, mism = 0;
    bit  poked1 = 0, poked2 = 0, aborted = 0;
    logic [31:0] w;
    for (int k = 0; k < TOT; k++) mem[k] = 1'b0;
    @(negedge clk);
    start_v = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (lutrst_m) begin addr = 0; rstcyc++; end
      if (load_m) begin
        if (addr < TOT) mem[addr] = data_m;
        addr++;
        strobes++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
      end
      lut_ready_v = ready_en && (addr == TOT);
      start_v = 1'b0;
      if (pokes && strobes == 20 && !poked1) begin start_v = 1'b1; poked1 = 1; end
      if (pokes && lut_ready_v && !poked2) begin start_v = 1'b1; poked2 = 1; end
      if (abort_at > 0 && strobes == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero",
            32'({ready_m, lutrst_m, load_m, data_m, busy_m, done_m, error_m}), 32'h0);
        aborted = 1;
        break;
      end
      if (done_m || error_m) begin fin = cyc; break; end
      valid_v = 1'b1;
      data_v  = words[(widx > 7) ? 7 : widx];
      if (gaps && (widx == 1 || widx == 2) && gapcnt < 5 * widx && ready_m) begin
        valid_v = 1'b0;
        gapcnt++;
      end
      if (valid_v && ready_m) begin xfers++; widx++; end
    end
    valid_v = 1'b0;
    start_v = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      lut_ready_v = 1'b0;
      $display("load ww=%0d aborted after %0d strobes", ww, strobes);
      return;
    end
    chk("completion_within_budget", 32'(fin >= 0), 32'h1);
    chk("strobe_count", 32'(strobes), 32'(TOT));
    chk("lut_rst_cycles", 32'(rstcyc), 32'h1);
    chk("words_accepted", 32'(xfers), 32'((TOT + ww - 1) / ww));
    for (int k = 0; k < TOT; k++) begin
      w = words[k / ww];
      if (mem[k] !== w[k % ww]) mism++;
    end
    chk("lut_contents_mismatches", 32'(mism), 32'h0);
    chk("strobe_span", 32'(last_s - first_s + 1), 32'(gaps ? TOT + 10 : TOT));
    chk("busy_after_load", 32'(busy_m), 32'h0);
    if (ready_en) begin
      chk("done_set", 32'(done_m), 32'h1);
      chk("error_clear", 32'(error_m), 32'h0);
      chk("done_latency_le2", 32'((fin - last_s) <= 2), 32'h1);
    end else begin
      chk("error_set", 32'(error_m), 32'h1);
      chk("done_clear_on_error", 32'(done_m), 32'h0);
      chk("error_latency", 32'(fin - last_s), 32'd16);
    end
    if (pokes) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (lutrst_m) rstcyc++;
        chk("done_held_after_poke", 32'(done_m), 32'h1);
      end
      chk("no_extra_lut_rst", 32'(rstcyc), 32'h1);
    end
    lut_ready_v = 1'b0;
    $display("load ww=%0d gaps=%0d pokes=%0d strobes=%0d words=%0d done=%0d error=%0d",
             ww, gaps, pokes, strobes, xfers, done_m, error_m);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; sel = 1'b0; start_v = 1'b0; valid_v = 1'b0;
    data_v = '0; lut_ready_v = 1'b0; ready_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_w32",
        32'({ready_m, lutrst_m, load_m, data_m, busy_m, done_m, error_m}), 32'h0);
    sel = 1'b1;
    #1;
    chk("reset_outputs_w24",
        32'({ready_m, lutrst_m, load_m, data_m, busy_m, done_m, error_m}), 32'h0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    gen_words(1'b1, 1'b0); run_load(1'b0, 1'b0, 0, 32);
    gen_words(1'b0, 1'b0); run_load(1'b1, 1'b0, 0, 32);

    sel = 1'b1;
    gen_words(1'b0, 1'b1); run_load(1'b0, 1'b0, 0, 24);
    sel = 1'b0;

    ready_en = 1'b0;
    gen_words(1'b0, 1'b0); run_load(1'b0, 1'b0, 0, 32);
    ready_en = 1'b1;
    gen_words(1'b0, 1'b0); run_load(1'b0, 1'b0, 0, 32);

    gen_words(1'b0, 1'b0); run_load(1'b0, 1'b0, 50, 32);
    chk("idle_after_abort", 32'({busy_m, done_m, error_m}), 32'h0);
    gen_words(1'b0, 1'b0); run_load(1'b0, 1'b0, 0, 32);

    gen_words(1'b0, 1'b0); run_load(1'b0, 1'b1, 0, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
